// File: rtl/vram_dbuf_model.sv
// vram_dbuf_model
// Double-buffered VRAM model for the simulation top. Two banks are held in
// one array: the rasteriser port reads and writes the back bank (!front_o),
// and the scanout port reads the front bank. A swap request waits for
// vblank, stalls new accesses until every accepted read has returned, then
// toggles the front bank.
//
// Ports:
//   clk, reset_i          clock; synchronous active-low reset
//   vram_sel_i/_wr_i      access request / direction (1 = write)
//   vram_mask_i           per-lane write enables (DATA_W/MASK_W bits per lane)
//   vram_addr_i           back-bank word address (wraps modulo DEPTH)
//   vram_data_in_i        write data
//   vram_ready_o          access accepted when vram_sel_i & vram_ready_o
//   vram_wr_ack_o         one-cycle pulse the cycle after a write accept
//   vram_rd_valid_o       read data valid, RD_LATENCY cycles after accept
//   vram_data_out_o       read data, holds between valid pulses
//   swap_i, vblank_i      swap request pulse / vertical blanking level
//   swap_busy_o           swap pending or in progress
//   swap_done_o           one-cycle pulse when the banks toggle
//   front_o               current front bank index
//   scan_addr_i           front-bank scanout address
//   scan_data_o           front-bank word, one cycle after sampling
module vram_dbuf_model #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int MASK_W     = 4,
  parameter int DEPTH      = 65536,
  parameter int RD_LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset_i,
  input  logic              vram_sel_i,
  input  logic              vram_wr_i,
  input  logic [MASK_W-1:0] vram_mask_i,
  input  logic [ADDR_W-1:0] vram_addr_i,
  input  logic [DATA_W-1:0] vram_data_in_i,
  output logic              vram_ready_o,
  output logic              vram_wr_ack_o,
  output logic              vram_rd_valid_o,
  output logic [DATA_W-1:0] vram_data_out_o,
  input  logic              swap_i,
  input  logic              vblank_i,
  output logic              swap_busy_o,
  output logic              swap_done_o,
  output logic              front_o,
  input  logic [ADDR_W-1:0] scan_addr_i,
  output logic [DATA_W-1:0] scan_data_o
);

  localparam int LANE_W = DATA_W / MASK_W;
  localparam int IDX_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(RD_LATENCY + 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_SWAP    = 2'd3
  } state_t;

  // Bank index is the MSB of the array index: {bank, word}.
  logic [DATA_W-1:0] mem_r [2*DEPTH];

  state_t            state_r;
  state_t            state_nxt_s;
  logic              ready_r;
  logic              busy_r;
  logic              done_r;
  logic              front_r;
  logic              ready_nxt_s;
  logic              busy_nxt_s;
  logic              done_nxt_s;
  logic              wr_ack_r;
  logic [DATA_W-1:0] scan_data_r;
  logic [CNT_W-1:0]  inflight_r;

  logic              acc_s;
  logic              acc_wr_s;
  logic              acc_rd_s;
  logic [IDX_W:0]    acc_idx_s;
  logic [IDX_W:0]    scan_idx_s;
  logic [DATA_W-1:0] rd_word_s;
  logic [DATA_W-1:0] wr_word_s;

  logic              pipe_vld_r [RD_LATENCY];
  logic [DATA_W-1:0] pipe_dat_r [RD_LATENCY];

  assign acc_s      = vram_sel_i & ready_r;
  assign acc_wr_s   = acc_s & vram_wr_i;
  assign acc_rd_s   = acc_s & ~vram_wr_i;
  assign acc_idx_s  = {~front_r, vram_addr_i[IDX_W-1:0]};
  assign scan_idx_s = {front_r, scan_addr_i[IDX_W-1:0]};
  assign rd_word_s  = mem_r[acc_idx_s];

  // Masked write: disabled lanes keep the word's current contents.
  for (genvar g = 0; g < MASK_W; g++) begin : g_lane
    assign wr_word_s[g*LANE_W +: LANE_W] = vram_mask_i[g] ?
        vram_data_in_i[g*LANE_W +: LANE_W] : rd_word_s[g*LANE_W +: LANE_W];
  end

  // Back-bank write port; memory contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (acc_wr_s) begin
      mem_r[acc_idx_s] <= wr_word_s;
    end
  end

  // Read pipeline entry: data is captured at accept so a later swap or
  // write cannot change what an in-flight read returns.
  always_ff @(posedge clk) begin
    if (!reset_i) begin
      pipe_vld_r[0] <= 1'b0;
      pipe_dat_r[0] <= {DATA_W{1'b0}};
    end else begin
      pipe_vld_r[0] <= acc_rd_s;
      if (acc_rd_s) begin
        pipe_dat_r[0] <= rd_word_s;
      end
    end
  end

  // Data only advances with a valid entry, so the last stage holds its
  // value between read returns.
  for (genvar k = 1; k < RD_LATENCY; k++) begin : g_pipe
    // Read pipeline stage k.
    always_ff @(posedge clk) begin
      if (!reset_i) begin
        pipe_vld_r[k] <= 1'b0;
        pipe_dat_r[k] <= {DATA_W{1'b0}};
      end else begin
        pipe_vld_r[k] <= pipe_vld_r[k-1];
        if (pipe_vld_r[k-1]) begin
          pipe_dat_r[k] <= pipe_dat_r[k-1];
        end
      end
    end
  end

  // Reads accepted but not yet presented; a read leaves the count on the
  // edge that ends its rd_valid cycle.
  always_ff @(posedge clk) begin
    if (!reset_i) begin
      inflight_r <= {CNT_W{1'b0}};
    end else begin
      inflight_r <= inflight_r + CNT_W'(acc_rd_s) - CNT_W'(pipe_vld_r[RD_LATENCY-1]);
    end
  end

  // Swap FSM state register.
  always_ff @(posedge clk) begin
    if (!reset_i) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Swap FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (swap_i) state_nxt_s = ST_PENDING;
        else        state_nxt_s = ST_IDLE;
      end
      ST_PENDING: begin
        if (vblank_i) state_nxt_s = ST_DRAIN;
        else          state_nxt_s = ST_PENDING;
      end
      ST_DRAIN: begin
        if (inflight_r == {CNT_W{1'b0}}) state_nxt_s = ST_SWAP;
        else                             state_nxt_s = ST_DRAIN;
      end
      ST_SWAP: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Swap FSM output decode, taken from the next state so the registered
  // outputs line up with the state they describe.
  always_comb begin
    ready_nxt_s = 1'b1;
    busy_nxt_s  = 1'b0;
    done_nxt_s  = 1'b0;
    case (state_nxt_s)
      ST_IDLE: begin
        ready_nxt_s = 1'b1;
        busy_nxt_s  = 1'b0;
        done_nxt_s  = 1'b0;
      end
      ST_PENDING: begin
        ready_nxt_s = 1'b1;
        busy_nxt_s  = 1'b1;
        done_nxt_s  = 1'b0;
      end
      ST_DRAIN: begin
        ready_nxt_s = 1'b0;
        busy_nxt_s  = 1'b1;
        done_nxt_s  = 1'b0;
      end
      ST_SWAP: begin
        ready_nxt_s = 1'b0;
        busy_nxt_s  = 1'b1;
        done_nxt_s  = 1'b1;
      end
      default: begin
        ready_nxt_s = 1'b1;
        busy_nxt_s  = 1'b0;
        done_nxt_s  = 1'b0;
      end
    endcase
  end

  // Registered swap outputs; the front bank toggles on the edge entering SWAP.
  always_ff @(posedge clk) begin
    if (!reset_i) begin
      ready_r <= 1'b1;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      front_r <= 1'b0;
    end else begin
      ready_r <= ready_nxt_s;
      busy_r  <= busy_nxt_s;
      done_r  <= done_nxt_s;
      front_r <= front_r ^ done_nxt_s;
    end
  end

  // Write acknowledge and scanout registers.
  always_ff @(posedge clk) begin
    if (!reset_i) begin
      wr_ack_r    <= 1'b0;
      scan_data_r <= {DATA_W{1'b0}};
    end else begin
      wr_ack_r    <= acc_wr_s;
      scan_data_r <= mem_r[scan_idx_s];
    end
  end

  assign vram_ready_o    = ready_r;
  assign vram_wr_ack_o   = wr_ack_r;
  assign vram_rd_valid_o = pipe_vld_r[RD_LATENCY-1];
  assign vram_data_out_o = pipe_dat_r[RD_LATENCY-1];
  assign swap_busy_o     = busy_r;
  assign swap_done_o     = done_r;
  assign front_o         = front_r;
  assign scan_data_o     = scan_data_r;

endmodule

// File: tb/tb_vram_dbuf_model.sv
// Scoreboard bench for vram_dbuf_model. Two instances share the stimulus:
// u_a uses RD_LATENCY=2 with the full 64K depth, u_b uses RD_LATENCY=4 with
// DEPTH=256 so address wrap and the longer latency are exercised together.
module tb_vram_dbuf_model;

  localparam int LA = 2;
  localparam int LB = 4;

  typedef struct {
    logic [15:0] data;
    int          due;
  } rd_exp_t;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        sel, wr, swap, vblank;
  logic [3:0]  mask;
  logic [15:0] addr, din, scan_addr;

  logic        a_ready, a_wr_ack, a_rd_valid, a_busy, a_done, a_front;
  logic [15:0] a_dout, a_scan;
  logic        b_ready, b_wr_ack, b_rd_valid, b_busy, b_done, b_front;
  logic [15:0] b_dout, b_scan;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  rd_exp_t rd_qa[$];
  rd_exp_t rd_qb[$];
  int      wr_qa[$];
  int      wr_qb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  vram_dbuf_model #(.ADDR_W(16), .DATA_W(16), .MASK_W(4), .DEPTH(65536), .RD_LATENCY(LA)) u_a (
    .clk(clk), .reset_i(reset_i), .vram_sel_i(sel), .vram_wr_i(wr), .vram_mask_i(mask),
    .vram_addr_i(addr), .vram_data_in_i(din), .vram_ready_o(a_ready), .vram_wr_ack_o(a_wr_ack),
    .vram_rd_valid_o(a_rd_valid), .vram_data_out_o(a_dout), .swap_i(swap), .vblank_i(vblank),
    .swap_busy_o(a_busy), .swap_done_o(a_done), .front_o(a_front), .scan_addr_i(scan_addr),
    .scan_data_o(a_scan));

  vram_dbuf_model #(.ADDR_W(16), .DATA_W(16), .MASK_W(4), .DEPTH(256), .RD_LATENCY(LB)) u_b (
    .clk(clk), .reset_i(reset_i), .vram_sel_i(sel), .vram_wr_i(wr), .vram_mask_i(mask),
    .vram_addr_i(addr), .vram_data_in_i(din), .vram_ready_o(b_ready), .vram_wr_ack_o(b_wr_ack),
    .vram_rd_valid_o(b_rd_valid), .vram_data_out_o(b_dout), .swap_i(swap), .vblank_i(vblank),
    .swap_busy_o(b_busy), .swap_done_o(b_done), .front_o(b_front), .scan_addr_i(scan_addr),
    .scan_data_o(b_scan));

  // Monitor for instance A: pops expected responses as the DUT presents them.
  always @(negedge clk) begin
    rd_exp_t e;
    if (a_rd_valid) begin
      n_vec++;
      if (rd_qa.size() == 0) begin
        n_bad++;
        $display("FAIL a_rd_unexpected: got data=%h at cyc %0d, expected no rd_valid", a_dout, cyc);
      end else begin
        e = rd_qa.pop_front();
        if (a_dout !== e.data || cyc != e.due) begin
          n_bad++;
          $display("FAIL a_rd: got data=%h cyc=%0d, expected data=%h cyc=%0d", a_dout, cyc, e.data, e.due);
        end
      end
    end else if (rd_qa.size() != 0 && rd_qa[0].due <= cyc) begin
      n_vec++; n_bad++;
      e = rd_qa.pop_front();
      $display("FAIL a_rd_missing: got no rd_valid at cyc %0d, expected data=%h", cyc, e.data);
    end
    if (a_wr_ack) begin
      n_vec++;
      if (wr_qa.size() == 0) begin
        n_bad++;
        $display("FAIL a_wr_ack_unexpected: got ack at cyc %0d, expected none", cyc);
      end else if (wr_qa.pop_front() != cyc) begin
        n_bad++;
        $display("FAIL a_wr_ack_timing: got ack at cyc %0d, expected a different cycle", cyc);
      end
    end else if (wr_qa.size() != 0 && wr_qa[0] <= cyc) begin
      n_vec++; n_bad++;
      $display("FAIL a_wr_ack_missing: got no ack at cyc %0d, expected ack at %0d", cyc, wr_qa.pop_front());
    end
  end

  // Monitor for instance B.
  always @(negedge clk) begin
    rd_exp_t e;
    if (b_rd_valid) begin
      n_vec++;
      if (rd_qb.size() == 0) begin
        n_bad++;
        $display("FAIL b_rd_unexpected: got data=%h at cyc %0d, expected no rd_valid", b_dout, cyc);
      end else begin
        e = rd_qb.pop_front();
        if (b_dout !== e.data || cyc != e.due) begin
          n_bad++;
          $display("FAIL b_rd: got data=%h cyc=%0d, expected data=%h cyc=%0d", b_dout, cyc, e.data, e.due);
        end
      end
    end else if (rd_qb.size() != 0 && rd_qb[0].due <= cyc) begin
      n_vec++; n_bad++;
      e = rd_qb.pop_front();
      $display("FAIL b_rd_missing: got no rd_valid at cyc %0d, expected data=%h", cyc, e.data);
    end
    if (b_wr_ack) begin
      n_vec++;
      if (wr_qb.size() == 0) begin
        n_bad++;
        $display("FAIL b_wr_ack_unexpected: got ack at cyc %0d, expected none", cyc);
      end else if (wr_qb.pop_front() != cyc) begin
        n_bad++;
        $display("FAIL b_wr_ack_timing: got ack at cyc %0d, expected a different cycle", cyc);
      end
    end else if (wr_qb.size() != 0 && wr_qb[0] <= cyc) begin
      n_vec++; n_bad++;
      $display("FAIL b_wr_ack_missing: got no ack at cyc %0d, expected ack at %0d", cyc, wr_qb.pop_front());
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One-cycle request issued at a negedge; expectations pushed at the same time.
  task automatic issue(input logic w, input logic [15:0] ad, input logic [15:0] d,
                       input logic [3:0] m, input logic [15:0] ea, input logic [15:0] eb,
                       input bit expect_rd);
    int guard = 0;
    rd_exp_t e;
    while (!(a_ready && b_ready) && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!(a_ready && b_ready)) begin
      n_vec++; n_bad++;
      $display("FAIL issue_ready: got ready a=%b b=%b, expected 1", a_ready, b_ready);
    end
    sel = 1'b1; wr = w; addr = ad; din = d; mask = m;
    if (w) begin
      wr_qa.push_back(cyc + 1);
      wr_qb.push_back(cyc + 1);
    end else if (expect_rd) begin
      e.data = ea; e.due = cyc + LA; rd_qa.push_back(e);
      e.data = eb; e.due = cyc + LB; rd_qb.push_back(e);
    end
    @(negedge clk);
    sel = 1'b0; wr = 1'b0;
  endtask

  task automatic wait_idle();
    int guard = 0;
    while ((rd_qa.size() + rd_qb.size() + wr_qa.size() + wr_qb.size()) != 0 && guard < 30) begin
      @(negedge clk);
      guard++;
    end
    chk("queues_drained", rd_qa.size() + rd_qb.size() + wr_qa.size() + wr_qb.size(), 32'd0);
  endtask

  initial begin
    bit a_seen, b_seen, a_low, b_low;
    reset_i = 1'b0; sel = 1'b0; wr = 1'b0; swap = 1'b0; vblank = 1'b0;
    mask = 4'h0; addr = 16'h0; din = 16'h0; scan_addr = 16'h0010;
    repeat (2) @(negedge clk);
    chk("rst_a_ready", a_ready, 1);   chk("rst_b_ready", b_ready, 1);
    chk("rst_a_wr_ack", a_wr_ack, 0); chk("rst_a_rd_valid", a_rd_valid, 0);
    chk("rst_a_dout", a_dout, 0);     chk("rst_b_dout", b_dout, 0);
    chk("rst_a_busy", a_busy, 0);     chk("rst_a_done", a_done, 0);
    chk("rst_a_front", a_front, 0);   chk("rst_b_front", b_front, 0);
    chk("rst_a_scan", a_scan, 0);     chk("rst_b_scan", b_scan, 0);
    reset_i = 1'b1;
    @(negedge clk);

    // Basic write then read; front bank must not see the write.
    issue(1'b1, 16'h0010, 16'hABCD, 4'hF, 16'h0, 16'h0, 1'b0);
    issue(1'b0, 16'h0010, 16'h0, 4'h0, 16'hABCD, 16'hABCD, 1'b1);
    wait_idle();
    chk("a_scan_front_untouched", a_scan != 16'hABCD, 1);
    chk("b_scan_front_untouched", b_scan != 16'hABCD, 1);

    // Lane masking: lane i covers bits [4i+3:4i].
    issue(1'b1, 16'h0007, 16'h1234, 4'hF, 16'h0, 16'h0, 1'b0);
    issue(1'b1, 16'h0007, 16'hFFFF, 4'h5, 16'h0, 16'h0, 1'b0);
    issue(1'b0, 16'h0007, 16'h0, 4'h0, 16'h1F3F, 16'h1F3F, 1'b1);
    issue(1'b1, 16'h0008, 16'h1234, 4'hF, 16'h0, 16'h0, 1'b0);
    issue(1'b1, 16'h0008, 16'hFFFF, 4'hA, 16'h0, 16'h0, 1'b0);
    issue(1'b0, 16'h0008, 16'h0, 4'h0, 16'hF2F4, 16'hF2F4, 1'b1);
    issue(1'b1, 16'h0008, 16'h0000, 4'h0, 16'h0, 16'h0, 1'b0);
    issue(1'b0, 16'h0008, 16'h0, 4'h0, 16'hF2F4, 16'hF2F4, 1'b1);
    wait_idle();

    // Back-to-back reads keep order at one result per cycle.
    for (int i = 1; i <= 4; i++) issue(1'b1, 16'(i), 16'(i * 16'h11), 4'hF, 16'h0, 16'h0, 1'b0);
    for (int i = 1; i <= 4; i++) issue(1'b0, 16'(i), 16'h0, 4'h0, 16'(i * 16'h11), 16'(i * 16'h11), 1'b1);
    wait_idle();

    // Swap: pending while vblank low, then drain two reads and toggle.
    swap = 1'b1;
    @(negedge clk);
    swap = 1'b0;
    chk("pend_a_busy", a_busy, 1);  chk("pend_a_ready", a_ready, 1);
    chk("pend_a_front", a_front, 0); chk("pend_b_busy", b_busy, 1);
    repeat (3) @(negedge clk);
    chk("pend_hold_a_busy", a_busy, 1); chk("pend_hold_b_ready", b_ready, 1);
    issue(1'b0, 16'h0010, 16'h0, 4'h0, 16'hABCD, 16'hABCD, 1'b1);
    issue(1'b0, 16'h0007, 16'h0, 4'h0, 16'h1F3F, 16'h1F3F, 1'b1);
    vblank = 1'b1;
    a_seen = 0; b_seen = 0; a_low = 0; b_low = 0;
    for (int i = 0; i < 20 && !(a_seen && b_seen); i++) begin
      @(negedge clk);
      if (!a_ready) a_low = 1;
      if (!b_ready) b_low = 1;
      if (a_done) begin
        a_seen = 1;
        chk("swap_a_front", a_front, 1); chk("swap_a_ready", a_ready, 0);
        chk("swap_a_drained", rd_qa.size(), 0);
      end
      if (b_done) begin
        b_seen = 1;
        chk("swap_b_front", b_front, 1); chk("swap_b_ready", b_ready, 0);
        chk("swap_b_drained", rd_qb.size(), 0);
      end
    end
    chk("swap_a_done_seen", a_seen, 1); chk("swap_b_done_seen", b_seen, 1);
    chk("drain_a_ready_low", a_low, 1); chk("drain_b_ready_low", b_low, 1);
    @(negedge clk);
    vblank = 1'b0;
    chk("post_a_ready", a_ready, 1); chk("post_b_ready", b_ready, 1);
    chk("post_a_busy", a_busy, 0);   chk("post_b_busy", b_busy, 0);
    chk("post_a_done", a_done, 0);   chk("post_b_front", b_front, 1);
    chk("post_a_scan", a_scan, 16'hABCD); chk("post_b_scan", b_scan, 16'hABCD);

    // Address wrap: only u_b (DEPTH=256) aliases 0x0105 onto 0x0005.
    issue(1'b1, 16'h0005, 16'h1111, 4'hF, 16'h0, 16'h0, 1'b0);
    issue(1'b1, 16'h0105, 16'h5A5A, 4'hF, 16'h0, 16'h0, 1'b0);
    issue(1'b0, 16'h0005, 16'h0, 4'h0, 16'h1111, 16'h5A5A, 1'b1);
    issue(1'b0, 16'h0105, 16'h0, 4'h0, 16'h5A5A, 16'h5A5A, 1'b1);
    wait_idle();

    // Reset mid-drain drops the in-flight read.
    swap = 1'b1;
    @(negedge clk);
    swap = 1'b0; vblank = 1'b1;
    issue(1'b0, 16'h0010, 16'h0, 4'h0, 16'h0, 16'h0, 1'b0);
    reset_i = 1'b0;
    chk("drain_a_ready", a_ready, 0); chk("drain_b_ready", b_ready, 0);
    @(negedge clk);
    reset_i = 1'b1; vblank = 1'b0;
    chk("mid_rst_a_front", a_front, 0); chk("mid_rst_b_front", b_front, 0);
    chk("mid_rst_a_busy", a_busy, 0);   chk("mid_rst_b_busy", b_busy, 0);
    chk("mid_rst_a_ready", a_ready, 1); chk("mid_rst_b_ready", b_ready, 1);
    repeat (6) @(negedge clk);
    chk("mid_rst_a_dout", a_dout, 0);   chk("mid_rst_b_dout", b_dout, 0);
    issue(1'b0, 16'h0010, 16'h0, 4'h0, 16'hABCD, 16'hABCD, 1'b1);
    issue(1'b0, 16'h0007, 16'h0, 4'h0, 16'h1F3F, 16'h1F3F, 1'b1);
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
